// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequencer for the shared HI/LO arithmetic resources of the multicycle CPU.
// It takes one request at a time (MULT, DIV, MTHI, MTLO). For MULT and DIV it
// latches the operands, pulses the start of the selected unit for one cycle,
// waits for that unit's end flag and commits its result into HI/LO. A DIV by
// zero is rejected before launch. busy lets the control unit stall MFHI/MFLO.
//
// Optional feature (compile-time macro MULDIV_TIMEOUT_EN):
//   defined   - WAIT is abandoned after TIMEOUT_CYCLES cycles without an end
//               flag; timeout_err pulses and HI/LO are left unchanged.
//   undefined - WAIT exits only on the end flag or reset; timeout_err is 0.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_op      request handshake and opcode (000 MULT, 001 DIV,
//   rs_val/rt_val         010 MTHI, 011 MTLO, others no effect) and operands
//   req_ready, busy       IDLE indication / not-IDLE indication
//   div_start/mult_start  one-cycle launch pulses
//   unit_a/unit_b         latched operands shared by both units
//   div_end/div_hi/div_lo divider done level and remainder/quotient
//   mult_end/mult_hi/lo   multiplier done level and product words
//   hi/lo                 architectural HI/LO registers
//   done/div0_exc/timeout_err  mutually exclusive one-cycle status pulses
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        req_ready,
  output logic        busy,
  output logic        div_start,
  output logic        mult_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        div_end,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        mult_end,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        div0_exc,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  // The WAIT counter must be able to represent TIMEOUT_CYCLES.
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
    $error("CNT_W is too narrow to hold TIMEOUT_CYCLES");
  end

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        use_div_q, use_div_d;   // 1: divider selected, 0: multiplier
  logic        done_q, done_d;
  logic        div0_q, div0_d;

`ifdef MULDIV_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // Only the recorded unit is observed; the other unit's end flag may be a
  // stale level left over from an earlier operation.
  logic        end_sel;
  logic [31:0] res_hi, res_lo;

  assign end_sel = use_div_q ? div_end : mult_end;
  assign res_hi  = use_div_q ? div_hi  : mult_hi;
  assign res_lo  = use_div_q ? div_lo  : mult_lo;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the case statements can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    use_div_d = use_div_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_MULT: begin
              a_d       = rs_val;
              b_d       = rt_val;
              use_div_d = 1'b0;
              state_d   = S_LAUNCH;
            end
            OP_DIV: begin
              if (rt_val == 32'd0) begin
                div0_d = 1'b1;
              end else begin
                a_d       = rs_val;
                b_d       = rt_val;
                use_div_d = 1'b1;
                state_d   = S_LAUNCH;
              end
            end
            OP_MTHI: begin
              hi_d   = rs_val;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs_val;
              done_d = 1'b1;
            end
            default: ;  // reserved opcodes are consumed without effect
          endcase
        end
      end

      // The start pulse is decoded from this state; end flags are not looked
      // at here because they still reflect the previous operation.
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef MULDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_WAIT: begin
        if (end_sel) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef MULDIV_TIMEOUT_EN
        // cnt_q counts completed WAIT cycles, so this fires at the end of
        // WAIT cycle number TIMEOUT_CYCLES.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      use_div_q <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      use_div_q <= use_div_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign div_start  = (state_q == S_LAUNCH) &&  use_div_q;
  assign mult_start = (state_q == S_LAUNCH) && !use_div_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;
  assign div0_exc   = div0_q;
`ifdef MULDIV_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed self-checking bench for muldiv_ctrl. Behavioural divider and
// multiplier models answer the start pulses after fixed latencies and hold
// their end flags high until the next start. All sampling happens 1 time unit
// after the falling clock edge; inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

  localparam int DIV_LAT  = 10;
  localparam int MULT_LAT = 33;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        req_ready, busy, div_start, mult_start;
  logic [31:0] unit_a, unit_b, hi, lo;
  logic        div_end = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0;
  logic        mult_end = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0;
  logic        done, div0_exc, timeout_err;

  muldiv_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .rs_val(rs_val), .rt_val(rt_val),
    .req_ready(req_ready), .busy(busy),
    .div_start(div_start), .mult_start(mult_start),
    .unit_a(unit_a), .unit_b(unit_b),
    .div_end(div_end), .div_hi(div_hi), .div_lo(div_lo),
    .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo),
    .done(done), .div0_exc(div0_exc), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // ---------------- unit models ----------------
  int div_cnt = 0;
  int mult_cnt = 0;
  bit div_stuck = 1'b0;

  always @(posedge clock) begin
    if (div_start) begin
      div_end <= 1'b0;
      div_cnt <= DIV_LAT;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1 && !div_stuck) begin
        div_end <= 1'b1;
        div_hi  <= unit_a % unit_b;
        div_lo  <= unit_a / unit_b;
      end
    end
  end

  always @(posedge clock) begin
    if (mult_start) begin
      mult_end <= 1'b0;
      mult_cnt <= MULT_LAT;
    end else if (mult_cnt > 0) begin
      mult_cnt <= mult_cnt - 1;
      if (mult_cnt == 1) begin
        mult_end <= 1'b1;
        {mult_hi, mult_lo} <= 64'(unit_a) * 64'(unit_b);
      end
    end
  end

  // ---------------- pulse monitors ----------------
  int done_cnt = 0, div0_cnt = 0, tmo_cnt = 0;
  int dstart_cnt = 0, mstart_cnt = 0, busy_cnt = 0, overlap_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      done_cnt   += int'(done);
      div0_cnt   += int'(div0_exc);
      tmo_cnt    += int'(timeout_err);
      dstart_cnt += int'(div_start);
      mstart_cnt += int'(mult_start);
      busy_cnt   += int'(busy);
      if (int'(done) + int'(div0_exc) + int'(timeout_err) > 1) overlap_cnt++;
    end
  end

  // ---------------- helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Presents one request for a single cycle; returns in the cycle after the
  // accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    rs_val    = a;
    rt_val    = b;
    tick();
    req_valid = 1'b0;
  endtask

  // n = 1 in the cycle after acceptance; returns the cycle index in which the
  // selected pulse is seen, or max+1 when it never comes.
  task automatic wait_pulse(input bit want_tmo, input int max, output int n);
    n = 1;
    while (!(want_tmo ? timeout_err : done) && n <= max) begin
      tick();
      n++;
    end
  endtask

  int n, d_done, d_dstart, d_mstart, d_div0, not_ready;

  initial begin
    // ---- reset ----
    repeat (3) tick();
    reset = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_unit_a", unit_a, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_done", done, 1'b0);

    // ---- MTHI / MTLO ----
    issue(3'b010, 32'hDEADBEEF, 32'h0);
    check("mthi_done", done, 1'b1);
    check("mthi_hi", hi, 32'hDEADBEEF);
    issue(3'b011, 32'h12345678, 32'h0);
    check("mtlo_done", done, 1'b1);
    check("mtlo_lo", lo, 32'h12345678);
    check("mtlo_hi_kept", hi, 32'hDEADBEEF);
    tick();
    check("mt_done_count", done_cnt, 2);
    check("mt_never_busy", busy_cnt, 0);

    // ---- DIV 100 / 7 ----
    d_done = done_cnt; d_dstart = dstart_cnt;
    issue(3'b001, 32'd100, 32'd7);
    check("div_start", div_start, 1'b1);
    check("div_no_mstart", mult_start, 1'b0);
    check("div_unit_a", unit_a, 32'd100);
    check("div_unit_b", unit_b, 32'd7);
    check("div_busy", busy, 1'b1);
    wait_pulse(1'b0, 100, n);
    check("div_latency", n, DIV_LAT + 3);
    check("div_hi", hi, 32'd2);
    check("div_lo", lo, 32'd14);
    tick();
    check("div_done_width", done, 1'b0);
    check("div_done_count", done_cnt - d_done, 1);
    check("div_start_count", dstart_cnt - d_dstart, 1);

    // ---- DIV by zero ----
    d_dstart = dstart_cnt; d_div0 = div0_cnt;
    issue(3'b001, 32'd5, 32'd0);
    check("div0_exc", div0_exc, 1'b1);
    check("div0_no_start", div_start, 1'b0);
    check("div0_idle", busy, 1'b0);
    check("div0_hi", hi, 32'd2);
    check("div0_lo", lo, 32'd14);
    check("div0_unit_a_held", unit_a, 32'd100);
    check("div0_unit_b_held", unit_b, 32'd7);
    tick();
    check("div0_width", div0_exc, 1'b0);
    check("div0_count", div0_cnt - d_div0, 1);
    check("div0_start_count", dstart_cnt - d_dstart, 0);

    // ---- MULT 0xFFFFFFFF * 2, with a competing MTHI held during the op ----
    d_mstart = mstart_cnt;
    issue(3'b000, 32'hFFFFFFFF, 32'd2);
    check("mult_start", mult_start, 1'b1);
    check("mult_no_dstart", div_start, 1'b0);
    req_valid = 1'b1; req_op = 3'b010; rs_val = 32'h00000055;
    n = 1; not_ready = 0;
    while (!done && n <= 60) begin
      if (req_ready) not_ready++;
      tick();
      n++;
    end
    req_valid = 1'b0;
    check("mult_latency", n, MULT_LAT + 3);
    check("mult_ready_low", not_ready, 0);
    check("mult_hi", hi, 32'h00000001);
    check("mult_lo", lo, 32'hFFFFFFFE);
    tick();
    check("mult_req_ignored", hi, 32'h00000001);
    check("mult_done_width", done, 1'b0);
    check("mult_start_count", mstart_cnt - d_mstart, 1);

    // ---- back-to-back DIV: div_end (and mult_end) still high at launch ----
    d_done = done_cnt;
    issue(3'b001, 32'd50, 32'd8);
    check("b2b_div_start", div_start, 1'b1);
    wait_pulse(1'b0, 100, n);
    check("b2b_latency", n, DIV_LAT + 3);
    check("b2b_hi", hi, 32'd2);
    check("b2b_lo", lo, 32'd6);
    check("b2b_done_count", done_cnt - d_done, 1);

    // ---- reset while in WAIT ----
    issue(3'b000, 32'd3, 32'd4);
    repeat (4) tick();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("wrst_busy", busy, 1'b0);
    check("wrst_hi", hi, 32'h0);
    check("wrst_lo", lo, 32'h0);
    check("wrst_done", done, 1'b0);
    reset = 1'b0;
    d_done = done_cnt;
    repeat (45) tick();
    check("wrst_no_commit", done_cnt - d_done, 0);
    check("wrst_hi_after", hi, 32'h0);

`ifdef MULDIV_TIMEOUT_EN
    // ---- stuck divider ----
    d_done = done_cnt;
    div_stuck = 1'b1;
    issue(3'b001, 32'd9, 32'd3);
    wait_pulse(1'b1, 100, n);
    check("tmo_latency", n, 42);
    check("tmo_idle", busy, 1'b0);
    check("tmo_hi", hi, 32'h0);
    check("tmo_lo", lo, 32'h0);
    tick();
    check("tmo_width", timeout_err, 1'b0);
    check("tmo_no_done", done_cnt - d_done, 0);
    div_stuck = 1'b0;
`else
    check("tmo_never", tmo_cnt, 0);
`endif

    check("pulse_exclusive", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
